// File: rtl/cpu_arb_pkg.sv
// Shared types and widths for the CPU sram-like memory-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cpu_arb_pkg;

  // sram-like bus widths (mirrors mycpu.h)
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SIZE_W = 2;
  localparam int STRB_W = 4;

  // Default number of accepted-but-unanswered requests the arbiter tracks
  localparam int OST_DEPTH_DEF = 2;

  // Requester identity as stored in the ID FIFO
  typedef enum logic {
    REQ_ID_I = 1'b0,
    REQ_ID_D = 1'b1
  } req_id_e;

  // Grant state: free to arbitrate, or held for one requester
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_I = 2'd1,
    ST_LOCK_D = 2'd2
  } arb_state_e;

  // Lock state that holds the grant for a given requester
  function automatic arb_state_e lock_state(input req_id_e id);
    return (id == REQ_ID_D) ? ST_LOCK_D : ST_LOCK_I;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// Synchronous FIFO of 1-bit requester IDs, in address-accept order.
// Latency: push visible at head one cycle later; full/empty/head are registered-state decodes.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keeps count.
module arb_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0] ids_q, ids_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign head    = ids_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Next-state: write at wr_ptr, advance pointers (power-of-two wrap), track occupancy
  always_comb begin
    ids_d    = ids_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      ids_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ids_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      ids_q    <= ids_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// Shares one in-order sram-like memory port between fetch (I) and load/store (D) requesters.
// Latency: addr_ok in the same cycle as mem_addr_ok; data_ok/rdata combinational from mem_data_ok.
// Backpressure: grant held while mem_addr_ok is low; new requests blocked while OST_DEPTH are outstanding.
module cpu_sram_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int OST_DEPTH = OST_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              inst_sram_req,
  input  logic              inst_sram_wr,
  input  logic [SIZE_W-1:0] inst_sram_size,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [STRB_W-1:0] inst_sram_wstrb,
  input  logic [DATA_W-1:0] inst_sram_wdata,
  output logic              inst_sram_addr_ok,
  output logic              inst_sram_data_ok,
  output logic [DATA_W-1:0] inst_sram_rdata,

  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [SIZE_W-1:0] data_sram_size,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [STRB_W-1:0] data_sram_wstrb,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [DATA_W-1:0] data_sram_rdata,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [SIZE_W-1:0] mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state_q, state_d;
  logic       rst_dly_q, rst_dly_d;

  logic       out_blk;
  logic       gnt_vld;
  req_id_e    gnt_id;
  logic       gnt_req;
  logic       addr_hs;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_head;
  logic       fifo_pop;

  // Handshakes are suppressed while in reset and for the cycle right after it
  assign out_blk = reset | rst_dly_q;

  // Grant selection: a lock pins the owner, otherwise D wins over I
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = REQ_ID_I;
    case (state_q)
      ST_LOCK_I: begin
        gnt_vld = 1'b1;
        gnt_id  = REQ_ID_I;
      end
      ST_LOCK_D: begin
        gnt_vld = 1'b1;
        gnt_id  = REQ_ID_D;
      end
      default: begin
        if (data_sram_req) begin
          gnt_vld = 1'b1;
          gnt_id  = REQ_ID_D;
        end else if (inst_sram_req) begin
          gnt_vld = 1'b1;
          gnt_id  = REQ_ID_I;
        end
      end
    endcase
  end

  assign gnt_req = (gnt_id == REQ_ID_D) ? data_sram_req : inst_sram_req;
  assign mem_req = gnt_vld & gnt_req & ~fifo_full & ~out_blk;
  assign addr_hs = mem_req & mem_addr_ok;

  // Memory-port request fields follow the granted requester only
  always_comb begin
    mem_wr    = inst_sram_wr;
    mem_size  = inst_sram_size;
    mem_addr  = inst_sram_addr;
    mem_wstrb = inst_sram_wstrb;
    mem_wdata = inst_sram_wdata;
    if (gnt_id == REQ_ID_D) begin
      mem_wr    = data_sram_wr;
      mem_size  = data_sram_size;
      mem_addr  = data_sram_addr;
      mem_wstrb = data_sram_wstrb;
      mem_wdata = data_sram_wdata;
    end
  end

  assign inst_sram_addr_ok = addr_hs & (gnt_id == REQ_ID_I);
  assign data_sram_addr_ok = addr_hs & (gnt_id == REQ_ID_D);

  // Responses return in accept order; a response with nothing outstanding is dropped
  assign fifo_pop          = mem_data_ok & ~fifo_empty & ~out_blk;
  assign inst_sram_data_ok = fifo_pop & (fifo_head == REQ_ID_I);
  assign data_sram_data_ok = fifo_pop & (fifo_head == REQ_ID_D);
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  arb_id_fifo #(
    .DEPTH   (OST_DEPTH)
  ) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (addr_hs),
    .push_id (gnt_id == REQ_ID_D),
    .pop     (fifo_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // Next grant state: release on handshake, lock when a granted request is left waiting
  always_comb begin
    state_d   = state_q;
    rst_dly_d = 1'b0;
    if (out_blk) begin
      state_d = ST_IDLE;
    end else if (addr_hs) begin
      state_d = ST_IDLE;
    end else if (gnt_vld && gnt_req) begin
      state_d = lock_state(gnt_id);
    end
  end

  // Grant state and post-reset blanking registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rst_dly_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rst_dly_q <= rst_dly_d;
    end
  end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
module tb_cpu_sram_arbiter;

  localparam int OST = 2;

  logic        clk;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  cpu_sram_arbiter #(.OST_DEPTH(OST)) dut (
    .clk               (clk),
    .reset             (reset),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .mem_req           (mem_req),
    .mem_wr            (mem_wr),
    .mem_size          (mem_size),
    .mem_addr          (mem_addr),
    .mem_wstrb         (mem_wstrb),
    .mem_wdata         (mem_wdata),
    .mem_addr_ok       (mem_addr_ok),
    .mem_data_ok       (mem_data_ok),
    .mem_rdata         (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Outstanding requester IDs (0=I, 1=D) in accept order, the requester
  // currently holding the port (-1 = nobody), and the post-reset quiet cycle.
  int q[$];
  int owner    = -1;
  bit settle   = 1'b0;
  bit mvalid   = 1'b0;

  always @(negedge clk) begin
    int  sel;
    bit  sreq, e_mreq, hs, pop;
    int  hd;
    if (reset) begin
      chk("m_rst_mreq", mem_req, 0);
      chk("m_rst_iaok", inst_sram_addr_ok, 0);
      chk("m_rst_daok", data_sram_addr_ok, 0);
      chk("m_rst_idok", inst_sram_data_ok, 0);
      chk("m_rst_ddok", data_sram_data_ok, 0);
      q.delete();
      owner  = -1;
      settle = 1'b1;
      mvalid = 1'b1;
    end else if (mvalid && settle) begin
      chk("m_post_mreq", mem_req, 0);
      chk("m_post_aok", {inst_sram_addr_ok, data_sram_addr_ok}, 0);
      chk("m_post_dok", {inst_sram_data_ok, data_sram_data_ok}, 0);
      settle = 1'b0;
    end else if (mvalid) begin
      if (owner >= 0)         sel = owner;
      else if (data_sram_req) sel = 1;
      else if (inst_sram_req) sel = 0;
      else                    sel = -1;
      sreq   = (sel == 1) ? data_sram_req : (sel == 0) ? inst_sram_req : 1'b0;
      e_mreq = sreq && (q.size() < OST);
      hs     = e_mreq && mem_addr_ok;
      pop    = mem_data_ok && (q.size() > 0);
      hd     = pop ? q[0] : -1;

      chk("m_mem_req", mem_req, e_mreq);
      chk("m_iaok", inst_sram_addr_ok, hs && sel == 0);
      chk("m_daok", data_sram_addr_ok, hs && sel == 1);
      chk("m_idok", inst_sram_data_ok, pop && hd == 0);
      chk("m_ddok", data_sram_data_ok, pop && hd == 1);
      if (pop) begin
        chk("m_rdata", (hd == 0) ? inst_sram_rdata : data_sram_rdata, mem_rdata);
      end
      if (e_mreq) begin
        chk("m_addr",  mem_addr,  (sel == 1) ? data_sram_addr  : inst_sram_addr);
        chk("m_wr",    mem_wr,    (sel == 1) ? data_sram_wr    : inst_sram_wr);
        chk("m_size",  mem_size,  (sel == 1) ? data_sram_size  : inst_sram_size);
        chk("m_wstrb", mem_wstrb, (sel == 1) ? data_sram_wstrb : inst_sram_wstrb);
        chk("m_wdata", mem_wdata, (sel == 1) ? data_sram_wdata : inst_sram_wdata);
      end

      if (pop) void'(q.pop_front());
      if (hs)  q.push_back(sel);
      if (hs)        owner = -1;
      else if (sreq) owner = sel;
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_addr = 0;
    inst_sram_wstrb = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_addr = 0;
    data_sram_wstrb = 0; data_sram_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    nxt(); nxt();

    // first cycle after reset: request present but nothing may be issued
    reset = 0; data_sram_req = 1; data_sram_addr = 32'hD000_0010; mem_addr_ok = 1;
    @(negedge clk);
    chk("post_rst_mreq", mem_req, 0);
    chk("post_rst_daok", data_sram_addr_ok, 0);

    // D and I together: D wins, then I next cycle
    nxt(); inst_sram_req = 1; inst_sram_addr = 32'h1000_0000;
    @(negedge clk);
    chk("both_daok", data_sram_addr_ok, 1);
    chk("both_iaok", inst_sram_addr_ok, 0);
    chk("both_addr", mem_addr, 32'hD000_0010);
    nxt(); data_sram_req = 0;
    @(negedge clk);
    chk("next_iaok", inst_sram_addr_ok, 1);
    chk("next_addr", mem_addr, 32'h1000_0000);
    nxt(); inst_sram_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("head_d_ddok", data_sram_data_ok, 1);
    chk("head_d_idok", inst_sram_data_ok, 0);
    chk("head_d_rdata", data_sram_rdata, 32'h1111_1111);
    nxt(); mem_rdata = 32'h2222_2222;
    @(negedge clk);
    chk("then_i_idok", inst_sram_data_ok, 1);
    chk("then_i_ddok", data_sram_data_ok, 0);

    // I waits three cycles; D arriving meanwhile must not steal the port
    nxt(); mem_data_ok = 0; inst_sram_req = 1; inst_sram_addr = 32'h100;
    @(negedge clk);
    chk("lock_c0_mreq", mem_req, 1);
    chk("lock_c0_addr", mem_addr, 32'h100);
    nxt(); data_sram_req = 1; data_sram_addr = 32'h200;
    @(negedge clk);
    chk("lock_c1_addr", mem_addr, 32'h100);
    chk("lock_c1_daok", data_sram_addr_ok, 0);
    nxt();
    @(negedge clk);
    chk("lock_c2_addr", mem_addr, 32'h100);
    nxt(); mem_addr_ok = 1;
    @(negedge clk);
    chk("lock_c3_iaok", inst_sram_addr_ok, 1);
    chk("lock_c3_daok", data_sram_addr_ok, 0);
    nxt(); inst_sram_req = 0;
    @(negedge clk);
    chk("lock_c4_daok", data_sram_addr_ok, 1);
    chk("lock_c4_addr", mem_addr, 32'h200);

    // two outstanding: third request is held off, even during a pop
    nxt(); data_sram_req = 0; inst_sram_req = 1; inst_sram_addr = 32'h300;
    @(negedge clk);
    chk("full_mreq", mem_req, 0);
    chk("full_iaok", inst_sram_addr_ok, 0);
    nxt(); mem_data_ok = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("full_pop_idok", inst_sram_data_ok, 1);
    chk("full_pop_rdata", inst_sram_rdata, 32'h1234_5678);
    chk("full_pop_mreq", mem_req, 0);
    // push and pop together with one outstanding
    nxt(); mem_rdata = 32'h9ABC_DEF0;
    @(negedge clk);
    chk("pp_ddok", data_sram_data_ok, 1);
    chk("pp_rdata", data_sram_rdata, 32'h9ABC_DEF0);
    chk("pp_iaok", inst_sram_addr_ok, 1);
    chk("pp_addr", mem_addr, 32'h300);
    nxt(); inst_sram_req = 0; mem_data_ok = 0; data_sram_req = 1; data_sram_wr = 1;
    data_sram_addr = 32'h400; data_sram_wstrb = 4'hF; data_sram_wdata = 32'hCAFE_BABE;
    @(negedge clk);
    chk("wr_daok", data_sram_addr_ok, 1);
    chk("wr_memwr", mem_wr, 1);
    chk("wr_wdata", mem_wdata, 32'hCAFE_BABE);
    nxt(); data_sram_req = 0; data_sram_wr = 0; mem_data_ok = 1; mem_rdata = 32'hA;
    @(negedge clk);
    chk("pp_after_idok", inst_sram_data_ok, 1);
    chk("pp_after_ddok", data_sram_data_ok, 0);
    nxt();
    @(negedge clk);
    chk("wr_resp_ddok", data_sram_data_ok, 1);
    nxt();
    @(negedge clk);
    chk("empty_dok", {inst_sram_data_ok, data_sram_data_ok}, 0);

    // reset with two outstanding discards them
    nxt(); mem_data_ok = 0; inst_sram_req = 1;
    @(negedge clk);
    chk("pre_rst_iaok", inst_sram_addr_ok, 1);
    nxt(); inst_sram_req = 0; data_sram_req = 1;
    @(negedge clk);
    chk("pre_rst_daok", data_sram_addr_ok, 1);
    nxt(); data_sram_req = 0; reset = 1; mem_data_ok = 1;
    @(negedge clk);
    chk("in_rst_dok", {inst_sram_data_ok, data_sram_data_ok}, 0);
    nxt(); reset = 0;
    @(negedge clk);
    chk("rst_settle_dok", {inst_sram_data_ok, data_sram_data_ok}, 0);
    nxt();
    @(negedge clk);
    chk("rst_dropped_dok", {inst_sram_data_ok, data_sram_data_ok}, 0);
    nxt(); mem_data_ok = 0; data_sram_req = 1;
    @(negedge clk);
    chk("rst_cnt0_daok", data_sram_addr_ok, 1);
    nxt(); data_sram_req = 0; mem_data_ok = 1;
    @(negedge clk);
    chk("rst_cnt0_ddok", data_sram_data_ok, 1);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      nxt();
      reset           = ($urandom_range(0, 299) == 0);
      inst_sram_req   = ($urandom_range(0, 99) < 55);
      inst_sram_wr    = ($urandom_range(0, 99) < 10);
      inst_sram_size  = 2'($urandom_range(0, 3));
      inst_sram_addr  = $urandom;
      inst_sram_wstrb = 4'($urandom_range(0, 15));
      inst_sram_wdata = $urandom;
      data_sram_req   = ($urandom_range(0, 99) < 45);
      data_sram_wr    = ($urandom_range(0, 99) < 50);
      data_sram_size  = 2'($urandom_range(0, 3));
      data_sram_addr  = $urandom;
      data_sram_wstrb = 4'($urandom_range(0, 15));
      data_sram_wdata = $urandom;
      mem_addr_ok     = ($urandom_range(0, 99) < 65);
      mem_data_ok     = ($urandom_range(0, 99) < 50);
      mem_rdata       = $urandom;
    end
    nxt();
    reset = 0;
    nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_sram_arbiter.md
CPU_SRAM_ARBITER -- requirements
Module: cpu_sram_arbiter

Interface
REQ-001 Parameter: OST_DEPTH, 2, maximum outstanding accepted-but-unanswered requests (power of two, 2..4).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inst_sram_req/wr/size/addr/wstrb/wdata  input  1/1/2/32/4/32  fetch-side sram-like request.
REQ-005 inst_sram_addr_ok, inst_sram_data_ok  output  1 each; inst_sram_rdata  output  32.
REQ-006 data_sram_req/wr/size/addr/wstrb/wdata  input  1/1/2/32/4/32  load/store-side sram-like request.
REQ-007 data_sram_addr_ok, data_sram_data_ok  output  1 each; data_sram_rdata  output  32.
REQ-008 mem_req/wr/size/addr/wstrb/wdata  output  1/1/2/32/4/32  shared memory-port request.
REQ-009 mem_addr_ok, mem_data_ok  input  1 each; mem_rdata  input  32.

Function
REQ-010 Shall share one in-order sram-like memory port between fetch (I) and load/store (D) requesters.
REQ-011 Address handshake completes in a cycle where mem_req & mem_addr_ok; requester's addr_ok asserted in that same cycle, no added latency.
REQ-012 Grant state machine: IDLE, LOCK_I, LOCK_D.
REQ-013 IDLE: if data_sram_req, grant D; else if inst_sram_req, grant I (D fixed priority, older instruction).
REQ-014 If granted request not accepted this cycle (mem_addr_ok=0 or ID FIFO full), move to LOCK_I/LOCK_D; grant held until that requester's handshake completes, then IDLE.
REQ-015 While locked, the other requester's req is ignored even if higher priority; mem_* fields are driven from the locked requester only.
REQ-016 mem_req = granted requester's req & ~fifo_full; non-granted addr_ok = 0.
REQ-017 ID FIFO (OST_DEPTH entries, 1 bit: 0=I, 1=D) pushes grant ID on each completed address handshake.
REQ-018 On mem_data_ok with FIFO non-empty: pop head; head=I drives inst_sram_data_ok=1, head=D drives data_sram_data_ok=1; mem_rdata routed combinationally to both rdata outputs.
REQ-019 mem_data_ok with FIFO empty: ignored, no data_ok forwarded, no state change.
REQ-020 Full FIFO blocks new requests regardless of same-cycle pop (no addr_ok-from-data_ok path).
REQ-021 Simultaneous push and pop when not full: count unchanged, ordering preserved.
REQ-022 Pointers wrap modulo OST_DEPTH; count width clog2(OST_DEPTH)+1.
REQ-023 Writes count as outstanding and receive data_ok like reads.

Reset
REQ-024 reset: state IDLE, FIFO pointers/count 0; all *_addr_ok, *_data_ok, mem_req = 0 during and first cycle after.
REQ-025 Reset mid-transaction: outstanding IDs discarded; responses arriving after reset handled per REQ-019.

Structure
REQ-026 Requester-ID encoding, grant state encoding and default OST_DEPTH in shared package cpu_arb_pkg (alongside mycpu.h widths).
REQ-027 One sub-module: arb_id_fifo (synchronous FIFO, push/pop/full/empty/head).

Verification
REQ-028 D and I req same cycle, mem_addr_ok=1 -> data_sram_addr_ok=1, inst_sram_addr_ok=0; FIFO head=D; next cycle I granted.
REQ-029 I req, mem_addr_ok=0 for 3 cycles, D req rises cycle 1 -> mem_addr stays I address until I accepted cycle 3; D accepted cycle 4.
REQ-030 OST_DEPTH=2: I,D accepted, no data_ok -> third request sees mem_req=0; mem_data_ok returns rdata 0x1234_5678 -> inst_sram_data_ok=1, then 0x9ABC_DEF0 -> data_sram_data_ok=1.
REQ-031 Push and pop same cycle with count=1 -> count remains 1, correct routing of following data_ok.
REQ-032 mem_data_ok with empty FIFO -> both data_ok 0; reset with 2 outstanding -> count 0, later mem_data_ok dropped.
